// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with a per-register pending scoreboard.
//
// Reads are registered (one cycle of latency). A write landing in the same cycle
// as a read of the same address is forwarded to that read port. With ZERO_REG=1,
// register 0 reads as zero, ignores writes and is never pending. Addresses at or
// above NREGS are ignored on write/issue and read back as zero / not busy.
//
// Ports:
//   clk_i       clock, rising-edge
//   rst_ni      asynchronous active-low reset
//   rd_en_i     per-port read enable (low = hold that port's outputs)
//   rd_addr_i   read addresses, port p in [p*AW +: AW]
//   rd_data_o   registered read data, port p in [p*XLEN +: XLEN]
//   rd_busy_o   registered pending flag of the register read on port p
//   wr_en_i     writeback write enable
//   wr_addr_i   write address
//   wr_data_i   write data
//   iss_en_i    issue: mark the destination register pending
//   iss_addr_i  destination register of the issued instruction
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_RD-1:0]      rd_en_i,
  input  logic [NUM_RD*AW-1:0]   rd_addr_i,
  output logic [NUM_RD*XLEN-1:0] rd_data_o,
  output logic [NUM_RD-1:0]      rd_busy_o,
  input  logic                   wr_en_i,
  input  logic [AW-1:0]          wr_addr_i,
  input  logic [XLEN-1:0]        wr_data_i,
  input  logic                   iss_en_i,
  input  logic [AW-1:0]          iss_addr_i
);

  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  // An address is live when it is in range and is not the hardwired zero register.
  function automatic logic addr_live(input logic [AW-1:0] a);
    logic in_range;
    logic is_zero;
    in_range = ({1'b0, a} < NREGS_W);
    is_zero  = (ZERO_REG == 1) && (a == {AW{1'b0}});
    return in_range && !is_zero;
  endfunction

  logic [XLEN-1:0]  regs_r [NREGS];
  logic [NREGS-1:0] pending_r;
  logic [XLEN-1:0]  rd_data_s [NUM_RD];
  logic [NUM_RD-1:0] rd_busy_s;
  logic [AW-1:0]    rd_a_s [NUM_RD];
  logic [XLEN-1:0]  rd_data_r [NUM_RD];
  logic [NUM_RD-1:0] rd_busy_r;
  logic             wr_live_s;
  logic             iss_live_s;

  // Qualify write and issue with address liveness so dropped accesses touch nothing.
  always_comb begin
    wr_live_s  = wr_en_i && addr_live(wr_addr_i);
    iss_live_s = iss_en_i && addr_live(iss_addr_i);
  end

  // Register storage: one decoded write port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_r[r] <= {XLEN{1'b0}};
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (wr_live_s && (wr_addr_i == AW'(r))) begin
          regs_r[r] <= wr_data_i;
        end else begin
          regs_r[r] <= regs_r[r];
        end
      end
    end
  end

  // Scoreboard: issue wins over a same-cycle write because the newer producer is still outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_r <= {NREGS{1'b0}};
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (iss_live_s && (iss_addr_i == AW'(r))) begin
          pending_r[r] <= 1'b1;
        end else if (wr_live_s && (wr_addr_i == AW'(r))) begin
          pending_r[r] <= 1'b0;
        end else begin
          pending_r[r] <= pending_r[r];
        end
      end
    end
  end

  // Per-port read lookup with write forwarding; a forwarded write also hides the pending bit.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_a_s[p]    = rd_addr_i[p*AW +: AW];
      rd_data_s[p] = {XLEN{1'b0}};
      rd_busy_s[p] = 1'b0;
      if (addr_live(rd_a_s[p])) begin
        if (wr_live_s && (wr_addr_i == rd_a_s[p])) begin
          rd_data_s[p] = wr_data_i;
          rd_busy_s[p] = 1'b0;
        end else begin
          rd_data_s[p] = regs_r[rd_a_s[p]];
          rd_busy_s[p] = pending_r[rd_a_s[p]];
        end
      end else begin
        rd_data_s[p] = {XLEN{1'b0}};
        rd_busy_s[p] = 1'b0;
      end
    end
  end

  // Read output registers: capture on enable, otherwise hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < NUM_RD; p++) begin
        rd_data_r[p] <= {XLEN{1'b0}};
      end
      rd_busy_r <= {NUM_RD{1'b0}};
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        if (rd_en_i[p]) begin
          rd_data_r[p] <= rd_data_s[p];
          rd_busy_r[p] <= rd_busy_s[p];
        end else begin
          rd_data_r[p] <= rd_data_r[p];
          rd_busy_r[p] <= rd_busy_r[p];
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_out
    assign rd_data_o[p*XLEN +: XLEN] = rd_data_r[p];
  end
  assign rd_busy_o = rd_busy_r;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: self-checking bench for regfile_sb.
// Three instances share clock, reset and write/issue inputs:
//   dut_a: defaults (32 regs, 2 ports, ZERO_REG=1)
//   dut_b: ZERO_REG=0 (shares dut_a's read inputs)
//   dut_c: NREGS=24, NUM_RD=3 (own read inputs)
// A behavioural model (arrays) tracks register contents, pending flags and expected outputs.
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data_a;
  logic [63:0] rd_data_b;
  logic [1:0]  busy_a;
  logic [1:0]  busy_b;
  logic [2:0]  rd_en3;
  logic [14:0] rd_addr3;
  logic [95:0] rd_data_c;
  logic [2:0]  busy_c;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_regs [3][32];
  bit          m_pend [3][32];
  logic [31:0] m_data [3][3];
  bit          m_busy [3][3];

  regfile_sb dut_a (
    .clk_i(clk), .rst_ni(rst_n), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data_a), .rd_busy_o(busy_a), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .iss_en_i(iss_en), .iss_addr_i(iss_addr)
  );

  regfile_sb #(.ZERO_REG(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data_b), .rd_busy_o(busy_b), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .iss_en_i(iss_en), .iss_addr_i(iss_addr)
  );

  regfile_sb #(.NREGS(24), .NUM_RD(3)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .rd_en_i(rd_en3), .rd_addr_i(rd_addr3),
    .rd_data_o(rd_data_c), .rd_busy_o(busy_c), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .iss_en_i(iss_en), .iss_addr_i(iss_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] act_data(input int d, input int p);
    logic [31:0] v;
    case (d)
      0:       v = rd_data_a[p*32 +: 32];
      1:       v = rd_data_b[p*32 +: 32];
      default: v = rd_data_c[p*32 +: 32];
    endcase
    return v;
  endfunction

  function automatic logic act_busy(input int d, input int p);
    logic v;
    case (d)
      0:       v = busy_a[p];
      1:       v = busy_b[p];
      default: v = busy_c[p];
    endcase
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int r = 0; r < 32; r++) begin
        m_regs[d][r] = 32'h0;
        m_pend[d][r] = 1'b0;
      end
      for (int p = 0; p < 3; p++) begin
        m_data[d][p] = 32'h0;
        m_busy[d][p] = 1'b0;
      end
    end
  endtask

  // Apply one clock edge's worth of architectural rules to the model, using current inputs.
  task automatic model_step();
    int  nregs, np, a, wa, ia;
    bit  zero, wv, iv, en, v, hit;
    wa = int'(wr_addr);
    ia = int'(iss_addr);
    for (int d = 0; d < 3; d++) begin
      nregs = (d == 2) ? 24 : 32;
      np    = (d == 2) ? 3 : 2;
      zero  = (d != 1);
      wv = wr_en  && (wa < nregs) && !(zero && wa == 0);
      iv = iss_en && (ia < nregs) && !(zero && ia == 0);
      for (int p = 0; p < np; p++) begin
        en = (d == 2) ? rd_en3[p] : rd_en[p];
        a  = (d == 2) ? int'(rd_addr3[p*5 +: 5]) : int'(rd_addr[p*5 +: 5]);
        if (en) begin
          v   = (a < nregs) && !(zero && a == 0);
          hit = wv && (wa == a);
          m_data[d][p] = !v ? 32'h0 : (hit ? wr_data : m_regs[d][a]);
          m_busy[d][p] = v && m_pend[d][a] && !hit;
        end
      end
      if (wv) m_regs[d][wa] = wr_data;
      if (wv) m_pend[d][wa] = 1'b0;
      if (iv) m_pend[d][ia] = 1'b1;
    end
  endtask

  task automatic idle();
    rd_en = 2'b00; rd_addr = 10'd0; rd_en3 = 3'b000; rd_addr3 = 15'd0;
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0; iss_en = 1'b0; iss_addr = 5'd0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (act_data(d, 0) !== 32'h0 || act_busy(d, 0) !== 1'b0) begin
        errors++; $display("FAIL reset_out dut=%0d got=%h/%b exp=0/0", d, act_data(d, 0), act_busy(d, 0));
      end
    end
    for (int a = 0; a < 32; a += 2) begin
      rd_en = 2'b11; rd_addr = {5'(a + 1), 5'(a)};
      rd_en3 = 3'b111; rd_addr3 = {5'(a), 5'(a + 1), 5'(a)};
      tick();
      for (int d = 0; d < 3; d++) begin
        for (int p = 0; p < ((d == 2) ? 3 : 2); p++) begin
          checks++;
          if (act_data(d, p) !== 32'h0 || act_busy(d, p) !== 1'b0) begin
            errors++; $display("FAIL reset_read dut=%0d port=%0d addr=%0d got=%h/%b exp=0/0", d, p, a, act_data(d, p), act_busy(d, p));
          end
        end
      end
    end
    idle();
  endtask

  task automatic test_write_read();
    idle(); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; tick();
    idle(); rd_en = 2'b01; rd_addr = {5'd0, 5'd5}; rd_en3 = 3'b001; rd_addr3 = {10'd0, 5'd5}; tick();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (act_data(d, 0) !== 32'hDEADBEEF) begin
        errors++; $display("FAIL wr_rd_r5 dut=%0d got=%h exp=deadbeef", d, act_data(d, 0));
      end
    end
    idle(); wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h00001234; tick();
    idle(); rd_en = 2'b10; rd_addr = {5'd0, 5'd0}; rd_en3 = 3'b010; rd_addr3 = 15'd0; tick();
    checks++;
    if (act_data(0, 1) !== 32'h0) begin
      errors++; $display("FAIL zero_reg_on got=%h exp=0", act_data(0, 1));
    end
    checks++;
    if (act_data(1, 1) !== 32'h00001234) begin
      errors++; $display("FAIL zero_reg_off got=%h exp=00001234", act_data(1, 1));
    end
    checks++;
    if (act_data(2, 1) !== 32'h0) begin
      errors++; $display("FAIL zero_reg_c got=%h exp=0", act_data(2, 1));
    end
    checks++;
    if (act_data(0, 0) !== 32'hDEADBEEF) begin
      errors++; $display("FAIL hold_p0 got=%h exp=deadbeef", act_data(0, 0));
    end
    idle();
  endtask

  task automatic test_bypass();
    idle(); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
    rd_en = 2'b11; rd_addr = {5'd7, 5'd7}; tick();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (act_data(d, p) !== 32'hA5A5A5A5) begin
          errors++; $display("FAIL bypass dut=%0d port=%0d got=%h exp=a5a5a5a5", d, p, act_data(d, p));
        end
      end
    end
    idle(); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11112222; rd_addr = {5'd1, 5'd7}; tick();
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (act_data(0, p) !== 32'hA5A5A5A5) begin
        errors++; $display("FAIL rd_en_hold port=%0d got=%h exp=a5a5a5a5", p, act_data(0, p));
      end
    end
    idle();
  endtask

  task automatic test_scoreboard();
    idle(); iss_en = 1'b1; iss_addr = 5'd3; rd_en = 2'b01; rd_addr = {5'd0, 5'd3}; tick();
    checks++;
    if (busy_a[0] !== 1'b0) begin
      errors++; $display("FAIL iss_same_cycle got=%b exp=0", busy_a[0]);
    end
    idle(); rd_en = 2'b01; rd_addr = {5'd0, 5'd3}; tick();
    checks++;
    if (busy_a[0] !== 1'b1) begin
      errors++; $display("FAIL iss_busy got=%b exp=1", busy_a[0]);
    end
    idle(); wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hC0FFEE01; rd_en = 2'b01; rd_addr = {5'd0, 5'd3}; tick();
    checks++;
    if (busy_a[0] !== 1'b0 || act_data(0, 0) !== 32'hC0FFEE01) begin
      errors++; $display("FAIL wr_clears got=%h/%b exp=c0ffee01/0", act_data(0, 0), busy_a[0]);
    end
    idle(); iss_en = 1'b1; iss_addr = 5'd3; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0BADF00D; tick();
    idle(); rd_en = 2'b10; rd_addr = {5'd3, 5'd0}; tick();
    checks++;
    if (busy_a[1] !== 1'b1 || act_data(0, 1) !== 32'h0BADF00D) begin
      errors++; $display("FAIL iss_wr_same got=%h/%b exp=0badf00d/1", act_data(0, 1), busy_a[1]);
    end
    idle();
  endtask

  task automatic test_config24();
    idle(); wr_en = 1'b1; wr_addr = 5'd30; wr_data = 32'hFFFF0000; iss_en = 1'b1; iss_addr = 5'd31; tick();
    idle(); rd_en3 = 3'b011; rd_addr3 = {5'd0, 5'd31, 5'd30}; tick();
    checks++;
    if (act_data(2, 0) !== 32'h0 || busy_c[0] !== 1'b0) begin
      errors++; $display("FAIL oor_r30 got=%h/%b exp=0/0", act_data(2, 0), busy_c[0]);
    end
    checks++;
    if (busy_c[1] !== 1'b0) begin
      errors++; $display("FAIL oor_iss_r31 got=%b exp=0", busy_c[1]);
    end
    idle(); wr_en = 1'b1; wr_addr = 5'd1;  wr_data = 32'h11111111; tick();
    idle(); wr_en = 1'b1; wr_addr = 5'd2;  wr_data = 32'h22222222; tick();
    idle(); wr_en = 1'b1; wr_addr = 5'd23; wr_data = 32'h23232323; tick();
    idle(); rd_en3 = 3'b111; rd_addr3 = {5'd23, 5'd2, 5'd1}; tick();
    checks++;
    if (act_data(2, 0) !== 32'h11111111) begin
      errors++; $display("FAIL c_r1 got=%h exp=11111111", act_data(2, 0));
    end
    checks++;
    if (act_data(2, 1) !== 32'h22222222) begin
      errors++; $display("FAIL c_r2 got=%h exp=22222222", act_data(2, 1));
    end
    checks++;
    if (act_data(2, 2) !== 32'h23232323) begin
      errors++; $display("FAIL c_r23 got=%h exp=23232323", act_data(2, 2));
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle(); rd_en = 2'b11; rd_addr = {5'd3, 5'd7}; rd_en3 = 3'b111; rd_addr3 = {5'd23, 5'd2, 5'd1}; tick();
    idle(); wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55AA55AA; iss_en = 1'b1; iss_addr = 5'd10;
    #3 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      for (int p = 0; p < ((d == 2) ? 3 : 2); p++) begin
        checks++;
        if (act_data(d, p) !== 32'h0 || act_busy(d, p) !== 1'b0) begin
          errors++; $display("FAIL async_reset dut=%0d port=%0d got=%h/%b exp=0/0", d, p, act_data(d, p), act_busy(d, p));
        end
      end
    end
    idle();
    model_reset();
    #1 rst_n = 1'b1;
    rd_en = 2'b11; rd_addr = {5'd10, 5'd9}; rd_en3 = 3'b001; rd_addr3 = {10'd0, 5'd7}; tick();
    checks++;
    if (act_data(0, 0) !== 32'h0 || busy_a[1] !== 1'b0 || act_data(2, 0) !== 32'h0) begin
      errors++; $display("FAIL reset_discard got=%h/%b/%h exp=0/0/0", act_data(0, 0), busy_a[1], act_data(2, 0));
    end
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      wr_en    = ($urandom_range(0, 1) == 1);
      wr_addr  = 5'(($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      wr_data  = $urandom;
      iss_en   = ($urandom_range(0, 3) == 0);
      iss_addr = 5'(($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      rd_en    = 2'($urandom_range(0, 3));
      rd_en3   = 3'($urandom_range(0, 7));
      for (int p = 0; p < 2; p++) rd_addr[p*5 +: 5] = 5'($urandom_range(0, 7));
      for (int p = 0; p < 3; p++) rd_addr3[p*5 +: 5] = 5'(($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      tick();
      for (int d = 0; d < 3; d++) begin
        for (int p = 0; p < ((d == 2) ? 3 : 2); p++) begin
          checks++;
          if (act_data(d, p) !== m_data[d][p] || act_busy(d, p) !== m_busy[d][p]) begin
            errors++;
            $display("FAIL random cyc=%0d dut=%0d port=%0d got=%h/%b exp=%h/%b", c, d, p,
                     act_data(d, p), act_busy(d, p), m_data[d][p], m_busy[d][p]);
          end
        end
      end
    end
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_config24();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core's integer register file.
- Generic depth, width and read-port count; registered synchronous reads with write-to-read bypass; optional hardwired-zero register; per-register pending (scoreboard) bits for the decode stage's RAW hazard check.
- Sits between decode (read/issue) and writeback (write). Same block serves the integer file (ZERO_REG=1) and a future FP file (ZERO_REG=0).

Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of architectural registers (>=2, need not be a power of 2)
- NUM_RD, 2, number of independent read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never pending; 0 = register 0 is ordinary
- AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_ni  in  1  asynchronous active-low reset
- rd_en_i  in  NUM_RD  per-port read enable; low = hold that port's outputs
- rd_addr_i  in  NUM_RD*AW  read addresses, port p in bits [p*AW +: AW]
- rd_data_o  out  NUM_RD*XLEN  registered read data, port p in [p*XLEN +: XLEN]
- rd_busy_o  out  NUM_RD  registered pending flag for the register read on port p
- wr_en_i  in  1  writeback write enable
- wr_addr_i  in  AW  write address
- wr_data_i  in  XLEN  write data
- iss_en_i  in  1  issue: mark destination pending
- iss_addr_i  in  AW  destination register of the issued instruction

Behaviour:
- Reset (rst_ni low, asynchronous): all registers 0, all pending bits 0, rd_data_o 0, rd_busy_o 0. Reset mid-operation discards any in-flight write or issue.
- Read latency is 1 cycle. If rd_en_i[p]=1 at edge N, rd_data_o/rd_busy_o for port p reflect rd_addr_i[p] after edge N. If rd_en_i[p]=0, port p holds its previous outputs.
- Write: if wr_en_i=1, regs[wr_addr_i] <= wr_data_i at the edge.
- Bypass: if a read and a write target the same valid address in the same cycle, rd_data_o = wr_data_i (new value), on every port independently.
- Zero register (ZERO_REG=1):
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0, with no bypass, and rd_busy_o=0.
  - Issue to address 0 is ignored.
- Out-of-range address (>= NREGS):
  - Writes and issues are ignored.
  - Reads return data 0, busy 0.
- Scoreboard, per register r:
  - set if iss_en_i and iss_addr_i==r;
  - else clear if wr_en_i and wr_addr_i==r;
  - else hold.
  - Issue and write to the same register in the same cycle leaves it pending, because the newer producer is outstanding.
- rd_busy_o[p] = pending[a] & ~(wr_en_i & wr_addr_i==a), where a = rd_addr_i[p], sampled that cycle. A same-cycle write clears visibility; a same-cycle issue is not visible on a read in that cycle.
- Write to a non-pending register is legal: data updated, pending stays 0.
- Multiple ports reading the same address are allowed and get identical results.
- No other state. No combinational path from inputs to outputs.

Test Plan:
- Reset then reads of all addresses on both ports -> rd_data_o=0, rd_busy_o=0 one cycle after each rd_en. Assert rst_ni low mid-write -> outputs and regs return to 0 immediately, without waiting for a clock.
- Write 0xDEADBEEF to r5, read r5 next cycle -> 0xDEADBEEF. Write 0x1234 to r0 with ZERO_REG=1 -> r0 reads 0. Same with ZERO_REG=0 -> 0x1234.
- Same-cycle write r7=0xA5A5A5A5 and read r7 on port 0 and port 1 -> both ports show 0xA5A5A5A5 after that edge. Read with rd_en_i=0 -> outputs unchanged.
- Issue r3, then read r3 -> busy=1. Write r3 and read r3 in the same cycle -> busy=0 with new data. Issue and write r3 in the same cycle -> the next read shows busy=1.
- Configuration NREGS=24, NUM_RD=3: write to r30 is ignored and read of r30 returns 0/0. Three ports reading r1, r2 and r23 return the previously written values.
